// File: rtl/byte_stripe_n.sv
// byte_stripe_n: round-robin striper of DW-bit symbols (with K flags) across
// up to LANES output lanes. Run-time active lane count, flush with pad
// symbols, registered one-cycle word strobe and a wrapping word counter.
//
// Handshake: IN_VALID qualifies D/DK for the current edge and is always
// accepted (no ready). OUT_VALID is a one-cycle strobe with no backpressure;
// LANE_* hold the last emitted word between strobes.
module byte_stripe_n #(
    parameter int              LANES   = 4,
    parameter int              DW      = 8,
    parameter logic [DW-1:0]   PAD_SYM = 8'hF7,
    parameter int              PW      = $clog2(LANES)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IN_VALID,
    input  logic [DW-1:0]       D,
    input  logic                DK,
    input  logic [PW-1:0]       ACT_M1,
    input  logic                FLUSH,
    output logic [LANES*DW-1:0] LANE_DATA,
    output logic [LANES-1:0]    LANE_DK,
    output logic [LANES-1:0]    LANE_EN,
    output logic                OUT_VALID,
    output logic                OUT_PADDED,
    output logic [15:0]         WORD_CNT
);

    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       act_q, act_d;
    logic [DW-1:0]       stg_sym_q [LANES];
    logic [DW-1:0]       stg_sym_d [LANES];
    logic                stg_k_q   [LANES];
    logic                stg_k_d   [LANES];
    logic [LANES*DW-1:0] lane_data_q, lane_data_d;
    logic [LANES-1:0]    lane_dk_q, lane_dk_d;
    logic [LANES-1:0]    lane_en_q, lane_en_d;
    logic                out_valid_q, out_valid_d;
    logic                out_padded_q, out_padded_d;
    logic [15:0]         word_cnt_q, word_cnt_d;

    // Lane count in force for the word being filled: at a word boundary the
    // live ACT_M1 applies immediately, otherwise the value latched at the start.
    logic [PW-1:0] act_eff;
    logic          complete;
    logic          pad_emit;

    // Next-state: accept symbol, detect word completion or flush, build word.
    always_comb begin
        ptr_d        = ptr_q;
        act_d        = act_q;
        stg_sym_d    = stg_sym_q;
        stg_k_d      = stg_k_q;
        lane_data_d  = lane_data_q;
        lane_dk_d    = lane_dk_q;
        lane_en_d    = lane_en_q;
        out_valid_d  = 1'b0;
        out_padded_d = 1'b0;
        word_cnt_d   = word_cnt_q;

        act_eff  = (ptr_q == '0) ? ACT_M1 : act_q;
        complete = IN_VALID && (ptr_q == act_eff);
        pad_emit = FLUSH && (IN_VALID || (ptr_q != '0)) && !complete;

        if (ptr_q == '0) begin
            act_d = ACT_M1;
        end

        if (IN_VALID) begin
            stg_sym_d[ptr_q] = D;
            stg_k_d[ptr_q]   = DK;
            ptr_d            = ptr_q + PW'(1);
        end

        if (complete || pad_emit) begin
            ptr_d        = '0;
            out_valid_d  = 1'b1;
            out_padded_d = pad_emit;
            word_cnt_d   = word_cnt_q + 16'd1;
            for (int k = 0; k < LANES; k++) begin
                if (PW'(k) > act_eff) begin
                    lane_data_d[k*DW +: DW] = '0;
                    lane_dk_d[k]            = 1'b0;
                    lane_en_d[k]            = 1'b0;
                end else begin
                    lane_en_d[k] = 1'b1;
                    if (IN_VALID && (PW'(k) == ptr_q)) begin
                        // completing / last symbol bypasses the staging array
                        lane_data_d[k*DW +: DW] = D;
                        lane_dk_d[k]            = DK;
                    end else if ((PW'(k) > ptr_q) || ((PW'(k) == ptr_q) && !IN_VALID)) begin
                        // lane never filled in this word: only reachable on flush
                        lane_data_d[k*DW +: DW] = PAD_SYM;
                        lane_dk_d[k]            = 1'b1;
                    end else begin
                        lane_data_d[k*DW +: DW] = stg_sym_q[k];
                        lane_dk_d[k]            = stg_k_q[k];
                    end
                end
            end
        end
    end

    // State and output registers; reset discards any partial word.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr_q        <= '0;
            act_q        <= PW'(LANES - 1);
            for (int k = 0; k < LANES; k++) begin
                stg_sym_q[k] <= '0;
                stg_k_q[k]   <= 1'b0;
            end
            lane_data_q  <= '0;
            lane_dk_q    <= '0;
            lane_en_q    <= '0;
            out_valid_q  <= 1'b0;
            out_padded_q <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            act_q        <= act_d;
            stg_sym_q    <= stg_sym_d;
            stg_k_q      <= stg_k_d;
            lane_data_q  <= lane_data_d;
            lane_dk_q    <= lane_dk_d;
            lane_en_q    <= lane_en_d;
            out_valid_q  <= out_valid_d;
            out_padded_q <= out_padded_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign LANE_DATA  = lane_data_q;
    assign LANE_DK    = lane_dk_q;
    assign LANE_EN    = lane_en_q;
    assign OUT_VALID  = out_valid_q;
    assign OUT_PADDED = out_padded_q;
    assign WORD_CNT   = word_cnt_q;

endmodule

// File: tb/tb_byte_stripe_n.sv
// Self-checking bench for byte_stripe_n (LANES=4, DW=8). A symbol-count model
// builds each expected word; a negedge scoreboard checks every cycle's outputs.
module tb_byte_stripe_n;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int PW    = 2;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic [DW-1:0]       d;
    logic                dk;
    logic [PW-1:0]       act_m1;
    logic                flush;
    logic [LANES*DW-1:0] lane_data;
    logic [LANES-1:0]    lane_dk;
    logic [LANES-1:0]    lane_en;
    logic                out_valid;
    logic                out_padded;
    logic [15:0]         word_cnt;

    byte_stripe_n #(.LANES(LANES), .DW(DW), .PAD_SYM(8'hF7)) dut (
        .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .D(d), .DK(dk),
        .ACT_M1(act_m1), .FLUSH(flush), .LANE_DATA(lane_data), .LANE_DK(lane_dk),
        .LANE_EN(lane_en), .OUT_VALID(out_valid), .OUT_PADDED(out_padded),
        .WORD_CNT(word_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // expected word: {data, dk, en, padded, word_cnt}
    logic [56:0] exp_q[$];
    logic [39:0] hold_exp;   // {data, dk, en} last emitted

    // reference model state
    int          m_cnt;
    int          m_act;
    logic [7:0]  m_sym [LANES];
    logic        m_k   [LANES];
    logic [15:0] m_wc;
    bit          m_emit;

    task automatic model_reset();
        m_cnt    = 0;
        m_act    = LANES - 1;
        m_wc     = 16'd0;
        m_emit   = 0;
        hold_exp = '0;
        exp_q.delete();
    endtask

    task automatic model_push(input bit padded);
        logic [31:0] wd;
        logic [3:0]  wk;
        logic [3:0]  we;
        wd = '0; wk = '0; we = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i <= m_act) begin
                we[i] = 1'b1;
                if (i < m_cnt) begin
                    wd[i*8 +: 8] = m_sym[i];
                    wk[i]        = m_k[i];
                end else begin
                    wd[i*8 +: 8] = 8'hF7;
                    wk[i]        = 1'b1;
                end
            end
        end
        m_wc = m_wc + 16'd1;
        exp_q.push_back({wd, wk, we, padded, m_wc});
        m_cnt  = 0;
        m_emit = 1;
    endtask

    // driver: apply inputs for one edge and advance the model at that edge
    task automatic step(input bit v, input logic [7:0] sym, input bit k,
                        input int act, input bit fl);
        in_valid = v;
        d        = sym;
        dk       = k;
        act_m1   = act[PW-1:0];
        flush    = fl;
        @(posedge clk);
        m_emit = 0;
        if (m_cnt == 0) m_act = act;
        if (v) begin
            m_sym[m_cnt] = sym;
            m_k[m_cnt]   = k;
            m_cnt++;
        end
        if (v && (m_cnt == m_act + 1)) model_push(1'b0);
        else if (fl && (m_cnt != 0))   model_push(1'b1);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, LANES - 1, 0);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #12;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // scoreboard: every cycle, strobes against expected queue, holds otherwise
    always @(negedge clk) begin
        if (!rst) begin
            compared++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL strobe_unexpected: got data=%h cnt=%0d, required no strobe",
                             lane_data, word_cnt);
                end else begin
                    logic [56:0] e;
                    e = exp_q.pop_front();
                    hold_exp = e[56:17];
                    if ({lane_data, lane_dk, lane_en, out_padded, word_cnt} !== e) begin
                        mismatched++;
                        $display("FAIL word: got data=%h dk=%b en=%b pad=%b cnt=%h, required data=%h dk=%b en=%b pad=%b cnt=%h",
                                 lane_data, lane_dk, lane_en, out_padded, word_cnt,
                                 e[56:25], e[24:21], e[20:17], e[16], e[15:0]);
                    end
                end
            end else begin
                if ({lane_data, lane_dk, lane_en} !== hold_exp || out_padded !== 1'b0) begin
                    mismatched++;
                    $display("FAIL hold: got data=%h dk=%b en=%b pad=%b, required data=%h dk=%b en=%b pad=0",
                             lane_data, lane_dk, lane_en, out_padded,
                             hold_exp[39:8], hold_exp[7:4], hold_exp[3:0]);
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        compared++;
        if ({lane_data, lane_dk, lane_en, out_valid, out_padded, word_cnt} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got data=%h dk=%b en=%b v=%b p=%b cnt=%h, required all 0",
                     lane_data, lane_dk, lane_en, out_valid, out_padded, word_cnt);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1, i[7:0], 0, 3, 0);
            compared++;
            if (out_valid !== ((i % 4) == 0)) begin
                mismatched++;
                $display("FAIL basic_strobe_%0d: got %b, required %b", i, out_valid, (i % 4) == 0);
            end
            if (i == 4 || i == 8) begin
                compared++;
                if (lane_data !== ((i == 4) ? 32'h04030201 : 32'h08070605) || lane_en !== 4'hF) begin
                    mismatched++;
                    $display("FAIL basic_word_%0d: got data=%h en=%b", i, lane_data, lane_en);
                end
            end
        end
        compared++;
        if (word_cnt !== 16'd2 || out_padded !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_cnt: got cnt=%0d pad=%b, required 2/0", word_cnt, out_padded);
        end
        idle(2);
    endtask

    task automatic test_kflag();
        logic [7:0] syms [4];
        syms[0] = 8'hA0; syms[1] = 8'hA1; syms[2] = 8'hA2; syms[3] = 8'hA3;
        for (int i = 0; i < 4; i++) begin
            step(1, syms[i], (i == 1), 1, 0);
            if (i == 1 || i == 3) begin
                compared++;
                if (out_valid !== 1'b1 || lane_en !== 4'b0011 ||
                    lane_data !== ((i == 1) ? 32'h0000A1A0 : 32'h0000A3A2) ||
                    lane_dk !== ((i == 1) ? 4'b0010 : 4'b0000)) begin
                    mismatched++;
                    $display("FAIL kflag_%0d: got v=%b data=%h dk=%b en=%b",
                             i, out_valid, lane_data, lane_dk, lane_en);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_flush();
        step(1, 8'h11, 0, 3, 0);
        step(1, 8'h22, 0, 3, 0);
        step(0, 8'h00, 0, 3, 1);
        compared++;
        if (out_valid !== 1'b1 || out_padded !== 1'b1 ||
            lane_data !== 32'hF7F72211 || lane_dk !== 4'b1100) begin
            mismatched++;
            $display("FAIL flush: got v=%b p=%b data=%h dk=%b, required 1/1/f7f72211/1100",
                     out_valid, out_padded, lane_data, lane_dk);
        end
        // pointer back at lane 0: next four symbols form a clean word
        for (int i = 0; i < 4; i++) step(1, 8'h30 + i[7:0], 0, 3, 0);
        compared++;
        if (out_valid !== 1'b1 || lane_data !== 32'h33323130) begin
            mismatched++;
            $display("FAIL flush_realign: got v=%b data=%h, required 1/33323130", out_valid, lane_data);
        end
        idle(2);
    endtask

    task automatic test_act_change();
        step(1, 8'h41, 0, 3, 0);
        step(1, 8'h42, 0, 3, 0);
        step(1, 8'h43, 0, 1, 0);
        step(1, 8'h44, 0, 1, 0);
        compared++;
        if (out_valid !== 1'b1 || lane_en !== 4'hF || lane_data !== 32'h44434241) begin
            mismatched++;
            $display("FAIL act_change_cur: got v=%b en=%b data=%h", out_valid, lane_en, lane_data);
        end
        step(1, 8'h45, 0, 1, 0);
        step(1, 8'h46, 0, 1, 0);
        compared++;
        if (out_valid !== 1'b1 || lane_en !== 4'b0011 || lane_data !== 32'h00004645) begin
            mismatched++;
            $display("FAIL act_change_next: got v=%b en=%b data=%h", out_valid, lane_en, lane_data);
        end
        idle(2);
    endtask

    task automatic test_flush_complete();
        step(1, 8'h51, 0, 3, 0);
        step(1, 8'h52, 0, 3, 0);
        step(1, 8'h53, 0, 3, 0);
        step(1, 8'h54, 0, 3, 1);
        compared++;
        if (out_valid !== 1'b1 || out_padded !== 1'b0 || lane_data !== 32'h54535251) begin
            mismatched++;
            $display("FAIL flush_complete: got v=%b p=%b data=%h", out_valid, out_padded, lane_data);
        end
        step(0, 8'h00, 0, 3, 1);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_idle: got v=%b, required 0", out_valid);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        step(1, 8'h61, 0, 3, 0);
        step(1, 8'h62, 0, 3, 0);
        step(1, 8'h63, 0, 3, 0);
        in_valid = 1'b0;
        do_reset();
        compared++;
        if ({lane_data, lane_dk, lane_en, out_valid, out_padded, word_cnt} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: got data=%h v=%b cnt=%h, required 0", lane_data, out_valid, word_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h71 + i[7:0], 0, 3, 0);
            compared++;
            if (out_valid !== (i == 3)) begin
                mismatched++;
                $display("FAIL reset_mid_strobe_%0d: got %b", i, out_valid);
            end
        end
        compared++;
        if (lane_data !== 32'h74737271 || word_cnt !== 16'd1) begin
            mismatched++;
            $display("FAIL reset_mid_word: got data=%h cnt=%0d, required 74737271/1", lane_data, word_cnt);
        end
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end
        idle(3);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            step(1, 8'($urandom), $urandom_range(0, 1), 0, 0);
            if (i == 65534) begin
                compared++;
                if (word_cnt !== 16'hFFFF || lane_en !== 4'b0001) begin
                    mismatched++;
                    $display("FAIL wrap_ffff: got cnt=%h en=%b, required ffff/0001", word_cnt, lane_en);
                end
            end
        end
        compared++;
        if (word_cnt !== 16'h0000 || out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL wrap_zero: got cnt=%h v=%b, required 0000/1", word_cnt, out_valid);
        end
        idle(2);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        d        = '0;
        dk       = 1'b0;
        act_m1   = 2'd3;
        flush    = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_kflag();
        test_flush();
        test_act_change();
        test_flush_complete();
        test_reset_mid();
        test_random();
        test_wrap();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_words: got %0d words not emitted, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/byte_stripe_n.md
# byte_stripe_n

Parametrised successor of the 4-lane byte striper: distributes a serial stream of DW-bit symbols with control (K) flags round-robin across up to LANES output lanes. The active lane count is selectable at run time, and partial words can be flushed with pad symbols. A registered, word-aligned strobe replaces the old counter-derived timing. The block sits between the symbol source and the per-lane serialisers/encoders of the multi-lane link.

## Interface
Parameters:
- LANES, 4, number of physical lanes; legal values 2, 4, 8.
- DW, 8, symbol width in bits.
- PAD_SYM, 8'hF7, symbol written into unfilled lanes on flush; always carries K=1. Width DW.
- PW, $clog2(LANES), derived; width of the lane pointer and of ACT_M1.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  D/DK hold a symbol to accept this edge.
- D  in  DW  input symbol.
- DK  in  1  K-flag of input symbol.
- ACT_M1  in  PW  active lane count minus one; active lanes are 0..ACT_M1.
- FLUSH  in  1  pad and emit the current partial word.
- LANE_DATA  out  LANES*DW  lane k occupies bits [k*DW +: DW].
- LANE_DK  out  LANES  K-flag per lane.
- LANE_EN  out  LANES  bit k=1 iff lane k is active in the emitted word.
- OUT_VALID  out  1  one-cycle strobe: LANE_* hold a new word.
- OUT_PADDED  out  1  qualifies OUT_VALID: word was completed by flush.
- WORD_CNT  out  16  count of emitted words; wraps 16'hFFFF to 0.

## Operation
- State: lane pointer PTR[PW-1:0], latched active count ACT (ACT_M1 copy), staging array STG_D/STG_K[LANES], and output registers.
- ACT latch: ACT is loaded from ACT_M1 on every edge where PTR==0. Mid-word changes to ACT_M1 are ignored until the next word boundary.
- Accept: on an edge with IN_VALID=1, the block writes D/DK into STG[PTR].
  - If PTR==ACT (value in effect for this word), the word is complete. The block emits it and sets PTR to 0.
  - Otherwise PTR increments by 1.
- Emit: LANE_DATA/LANE_DK take STG lanes 0..ACT, with the completing symbol included the same edge. Inactive lanes (k>ACT) output data 0, DK 0. LANE_EN is set to the active-lane mask. OUT_VALID=1 and WORD_CNT increments.
- FLUSH while PTR!=0, or with IN_VALID=1 that does not complete the word:
  - After the byte is accepted, all unfilled active lanes get PAD_SYM/DK=1.
  - The word is emitted with OUT_PADDED=1, and PTR is set to 0.
- FLUSH with the completing symbol: normal emit, OUT_PADDED=0, no extra word.
- FLUSH with PTR==0 and IN_VALID=0: no effect.
- Between strobes, LANE_DATA/LANE_DK/LANE_EN hold the last emitted word. OUT_VALID and OUT_PADDED are 0.
- No backpressure: the downstream consumer must accept every OUT_VALID.

## Timing
- RESET asserted, at any time (including mid-word):
  - PTR=0, ACT=LANES-1, STG cleared.
  - LANE_DATA=0, LANE_DK=0, LANE_EN=0, OUT_VALID=0, OUT_PADDED=0, WORD_CNT=0.
  - The partial word is discarded; nothing is emitted.
- First edge after RESET deasserts behaves as PTR==0 (ACT latched from ACT_M1).
- Latency: the completing symbol accepted at edge t gives OUT_VALID high in the cycle after edge t, for exactly one cycle.
- Back-to-back: with continuous IN_VALID, ACT_M1=LANES-1, there is one OUT_VALID every LANES cycles, with no bubble between words.
- ACT_M1=0: every accepted symbol emits a word in lane 0 only (LANE_EN=...0001).
- Flush latency: FLUSH at edge t gives OUT_VALID high in the cycle after edge t.

## Test plan
- LANES=4, ACT_M1=3, continuous IN_VALID, D=0x01..0x08, DK=0. Required:
  - Two strobes, 4 cycles apart.
  - LANE_DATA=0x04030201 then 0x08070605; LANE_EN=4'hF.
  - WORD_CNT=2, OUT_PADDED=0.
- ACT_M1=1, D=0xA0..0xA3 with DK=1 on 0xA1. Required:
  - Words 0x0000A1A0 with LANE_DK=4'b0010, then 0x0000A3A2 with LANE_DK=4'b0000.
  - LANE_EN=4'b0011.
- ACT_M1=3, send 0x11,0x22, then FLUSH with IN_VALID=0. Required:
  - OUT_VALID and OUT_PADDED on the next cycle.
  - LANE_DATA=0xF7F72211, LANE_DK=4'b1100.
  - PTR returns to 0.
- ACT_M1 changes 3→1 after the 2nd symbol of a word. Required:
  - The current word still completes at 4 lanes.
  - The next word uses 2 lanes (LANE_EN=4'b0011).
- FLUSH together with the 4th symbol → a single normal word, OUT_PADDED=0. FLUSH when idle → no strobe.
- RESET pulse after 3 symbols. Required:
  - All outputs 0, no strobe.
  - Next 4 symbols form a complete word starting at lane 0.
- Run 65536 words to check that WORD_CNT wraps to 0.
